// File: rtl/sub_serial16.sv
// rtl/sub_serial16.sv - multi-cycle slice-serial two's-complement subtractor (a - b - b_in)
module sub_serial16 #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             carry_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;

    logic [SLICE:0]   sum_d;
    logic [WIDTH-1:0] res_d;
    logic             ovf_d;

    // One shared slice adder: subtraction as a + ~b + carry, carry seeded with ~b_in.
    always_comb begin
        sum_d = {1'b0, a_q[cnt_q*SLICE +: SLICE]}
              + {1'b0, ~b_q[cnt_q*SLICE +: SLICE]}
              + {{SLICE{1'b0}}, carry_q};
        res_d = res_q;
        res_d[cnt_q*SLICE +: SLICE] = sum_d[SLICE-1:0];
        ovf_d = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (res_d[WIDTH-1] ^ a_q[WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            carry_q  <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= ~b_in;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    res_q   <= res_d;
                    carry_q <= sum_d[SLICE];
                    cnt_q   <= cnt_q + 1'b1;
                    // Outputs only change here so partial slices never leak out.
                    if (cnt_q == LAST) begin
                        diff_q   <= res_d;
                        borrow_q <= ~sum_d[SLICE];
                        ovf_q    <= ovf_d;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign diff       = diff_q;
    assign borrow_out = borrow_q;
    assign overflow   = ovf_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
